shiftreg_arb_ctrl: RTL
======================

Name: shiftreg_arb_ctrl

Overview:
Controller that shares one parallel-load / serial-shift register between two requesters. It arbitrates round-robin, latches the granted word and drives the register's load and shift enables. It paces shifting at one bit per CLK_DIV clocks and flags completion. It sits between the requesters and a shift register whose serial output is taken from its MSB.

Parameters:
BITWIDTH, 32, width of a data word and of the shift register (>=2)
CLK_DIV, 4, clk cycles per serial bit period (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req0_val  input  1  requester 0 has a word
req0_data  input  BITWIDTH  requester 0 word
req0_rdy  output  1  requester 0 word accepted when val&rdy
req1_val  input  1  requester 1 has a word
req1_data  input  BITWIDTH  requester 1 word
req1_rdy  output  1  requester 1 word accepted when val&rdy
sr_load_en  output  1  shift register parallel load enable
sr_load_data  output  BITWIDTH  word to load
sr_shift_en  output  1  shift register shift enable (one-cycle pulse)
sel  output  1  owner of the word in flight
busy  output  1  high in LOAD, SHIFT and DONE
done  output  1  one-cycle pulse at end of word

Behaviour:
- Reset: state IDLE; sr_load_en=0, sr_shift_en=0, busy=0, done=0, sel=0, data latch=0, counters=0; last-grant=1, so req0 has first priority. reqN_rdy=0 in any cycle with reset high.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE, grant:
  - Only one val high: grant that requester.
  - Both high: grant the requester not granted last.
  - rdy is combinational, high only for the granted requester, and only in IDLE; the other rdy is 0.
- IDLE, on accept:
  - Latch data; sel<=winner; last-grant<=winner; next state LOAD.
  - With no val, stay in IDLE with outputs low.
- LOAD (1 cycle): sr_load_en=1; sr_load_data=latched word (held stable in all states). Next state SHIFT.
- SHIFT:
  - div counter runs 0..CLK_DIV-1 and wraps; bit counter runs 0..BITWIDTH-1.
  - sr_shift_en=1 in a cycle exactly when div==CLK_DIV-1; the bit counter increments on each pulse.
  - The pulse with bit==BITWIDTH-1 is the last one; next state DONE, counters cleared.
  - CLK_DIV=1 gives a pulse every cycle.
- DONE (1 cycle): done=1. Next state IDLE. A new word can be accepted in the following cycle.
- Timing for accept at cycle T:
  - load at T+1;
  - shift pulses at T+1+k*CLK_DIV for k=1..BITWIDTH;
  - done at T+2+BITWIDTH*CLK_DIV.
- Exactly BITWIDTH shift pulses are issued per word. Each bit is presented at the register MSB for CLK_DIV cycles.
- val going low while busy has no effect. rdy stays 0 until IDLE.
- sr_load_en and sr_shift_en are never high in the same cycle.
- Reset mid-word: the word is abandoned, nothing more is issued and done is not pulsed. Priority returns to req0.

Optional Feature:
SHIFTREG_ARB_CTRL_ABORT_EN:
- Defined: adds input abort (1 bit). If abort=1 in LOAD or SHIFT:
  - sr_load_en and sr_shift_en are forced 0 that cycle.
  - Next state is IDLE and counters are cleared.
  - done is not pulsed.
  - last-grant keeps the aborted requester, so the other requester wins the next tie.
  - abort is ignored in IDLE and DONE.
- Not defined: no abort port; every accepted word runs to DONE.

Test Plan:
BITWIDTH=8, CLK_DIV=2.
- Single word: req0_val=1, data=8'hA5 accepted at T -> load_en at T+1 with 8'hA5; shift pulses at T+3,5,...,17 (8 pulses); done at T+18; sel=0; req0_rdy=0 during T+1..T+18.
- Contention: both val high from reset -> req0 served first, then req1, then req0; sel=0,1,0; each done 17 cycles after its load.
- Back-to-back: req1_val held high with 8'h3C then 8'h5A -> second accept exactly 1 cycle after the first done; no overlap of load_en and shift_en.
- Mid-word reset: assert reset at T+6 -> all outputs 0 next cycle; no done pulse; req0 wins next tie.
- CLK_DIV=1 (separate build): accept at T -> pulses at T+2..T+9, done at T+10.
- Abort (macro defined): abort at T+6 -> no pulses after T+5; no done; IDLE at T+7; with both val high, req1 is granted.

Source files
------------

// File: rtl/shiftreg_arb_ctrl.sv
// Round-robin owner of one load/shift register; optional abort input under SHIFTREG_ARB_CTRL_ABORT_EN.
// Latency: load 1 cycle after accept, done 2+BITWIDTH*CLK_DIV after; rdy held low until IDLE.
module shiftreg_arb_ctrl #(
    parameter int BITWIDTH = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef SHIFTREG_ARB_CTRL_ABORT_EN
    input  logic                abort,
`endif
    input  logic                req0_val,
    input  logic [BITWIDTH-1:0] req0_data,
    output logic                req0_rdy,
    input  logic                req1_val,
    input  logic [BITWIDTH-1:0] req1_data,
    output logic                req1_rdy,
    output logic                sr_load_en,
    output logic [BITWIDTH-1:0] sr_load_data,
    output logic                sr_shift_en,
    output logic                sel,
    output logic                busy,
    output logic                done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(BITWIDTH);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BITWIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bit;
    logic [BITWIDTH-1:0] r_data;
    logic                r_sel;
    logic                r_last;
    logic                w_abort;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_accept;
    logic                w_pulse;
    logic                w_last_pulse;

`ifdef SHIFTREG_ARB_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // On a tie the requester that did not win last time is granted.
    assign w_gnt0       = req0_val && (!req1_val || r_last);
    assign w_gnt1       = req1_val && (!req0_val || !r_last);
    assign w_accept     = req0_rdy || req1_rdy;
    assign w_pulse      = (r_div == DIV_MAX);
    assign w_last_pulse = w_pulse && (r_bit == BIT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_abort ? S_IDLE : S_SHIFT;
            S_SHIFT: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_pulse) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        sr_load_en   = 1'b0;
        sr_shift_en  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        sr_load_data = r_data;
        sel          = r_sel;
        case (r_state)
            S_IDLE: begin
                req0_rdy = w_gnt0 && !reset;
                req1_rdy = w_gnt1 && !reset;
            end
            S_LOAD: begin
                busy       = 1'b1;
                sr_load_en = !w_abort;
            end
            S_SHIFT: begin
                busy        = 1'b1;
                sr_shift_en = w_pulse && !w_abort;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters only run in SHIFT; the final pulse wraps both back to zero.
    always_ff @(posedge clk) begin
        if (reset || r_state != S_SHIFT || w_abort) begin
            r_div <= '0;
            r_bit <= '0;
        end else if (w_pulse) begin
            r_div <= '0;
            r_bit <= (r_bit == BIT_MAX) ? '0 : r_bit + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_sel  <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_data <= w_gnt1 ? req1_data : req0_data;
            r_sel  <= w_gnt1;
            r_last <= w_gnt1;
        end
    end

endmodule
